// File: rtl/ths8200_pkg.sv
// Shared types and constants for the THS8200 power-up configuration sequencer.
// THS8200_CFG_VERIFY_EN adds the read-back states to the FSM enum.
package ths8200_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_NEXT,
        ST_GAP,
        ST_DONE,
        ST_FAIL,
        ST_DRAIN
`ifdef THS8200_CFG_VERIFY_EN
        ,
        ST_RDREQ,
        ST_RDWAIT
`endif
    } cfg_state_e;

    // THS8200 register map (subset touched at power-up)
    localparam logic [7:0] REG_CHIP_CTL         = 8'h03;
    localparam logic [7:0] REG_CSC_OFFS3        = 8'h19;
    localparam logic [7:0] REG_DATA_CNTL        = 8'h1C;
    localparam logic [7:0] REG_DTG1_Y_MSB       = 8'h1D;
    localparam logic [7:0] REG_DTG1_Y_BLANK     = 8'h1E;
    localparam logic [7:0] REG_DTG1_Y_SYNC_LO   = 8'h1F;
    localparam logic [7:0] REG_DTG1_Y_SYNC_HI   = 8'h20;
    localparam logic [7:0] REG_DTG1_C_MSB       = 8'h21;
    localparam logic [7:0] REG_DTG1_C_BLANK     = 8'h22;
    localparam logic [7:0] REG_DTG1_C_SYNC_LO   = 8'h23;
    localparam logic [7:0] REG_DTG1_C_SYNC_HI   = 8'h24;
    localparam logic [7:0] REG_DTG1_SPEC_A      = 8'h28;
    localparam logic [7:0] REG_DTG1_SPEC_B      = 8'h29;
    localparam logic [7:0] REG_DTG1_SPEC_C      = 8'h2A;
    localparam logic [7:0] REG_DTG1_SPEC_D      = 8'h2B;
    localparam logic [7:0] REG_DTG1_TOT_PIX_MSB = 8'h34;
    localparam logic [7:0] REG_DTG1_TOT_PIX_LSB = 8'h35;
    localparam logic [7:0] REG_DTG1_MODE        = 8'h38;
    localparam logic [7:0] REG_DTG1_FRM_MSB     = 8'h39;
    localparam logic [7:0] REG_DTG1_FRM_LSB     = 8'h3A;
    localparam logic [7:0] REG_DTG1_FLD_LSB     = 8'h3B;
    localparam logic [7:0] REG_DTG1_ACT_MSB     = 8'h3C;
    localparam logic [7:0] REG_DTG1_ACT_LSB     = 8'h3D;
    localparam logic [7:0] REG_DTG2_CNTL        = 8'h4A;

    localparam logic [7:0] CHIP_CTL_ON   = 8'h01;
    localparam logic [7:0] CSC_BYPASS    = 8'h03;
    localparam logic [7:0] DTG_MODE_720P = 8'h81;

    // 720p60 raster
    localparam logic [15:0] TOT_PIX   = 16'd1650;
    localparam logic [15:0] TOT_LINES = 16'd750;
    localparam logic [15:0] ACT_START = 16'd371;

endpackage

// File: rtl/ths8200_reg_rom.sv
// Index to {register address, data} lookup for the 720p 4:2:2 embedded-sync setup.
module ths8200_reg_rom
    import ths8200_pkg::*;
(
    input  logic [7:0] idx_i,
    output logic [7:0] addr_o,
    output logic [7:0] data_o
);

    always_comb begin
        {addr_o, data_o} = 16'h0000;
        case (idx_i)
            8'd0:  {addr_o, data_o} = {REG_CHIP_CTL,         CHIP_CTL_ON};
            8'd1:  {addr_o, data_o} = {REG_CSC_OFFS3,        CSC_BYPASS};
            8'd2:  {addr_o, data_o} = {REG_DATA_CNTL,        8'h03};
            8'd3:  {addr_o, data_o} = {REG_DTG1_Y_MSB,       8'h15};
            8'd4:  {addr_o, data_o} = {REG_DTG1_Y_BLANK,     8'h00};
            8'd5:  {addr_o, data_o} = {REG_DTG1_Y_SYNC_LO,   8'h00};
            8'd6:  {addr_o, data_o} = {REG_DTG1_Y_SYNC_HI,   8'hFF};
            8'd7:  {addr_o, data_o} = {REG_DTG1_C_MSB,       8'h15};
            8'd8:  {addr_o, data_o} = {REG_DTG1_C_BLANK,     8'h00};
            8'd9:  {addr_o, data_o} = {REG_DTG1_C_SYNC_LO,   8'h00};
            8'd10: {addr_o, data_o} = {REG_DTG1_C_SYNC_HI,   8'hFF};
            8'd11: {addr_o, data_o} = {REG_DTG1_SPEC_A,      8'h28};
            8'd12: {addr_o, data_o} = {REG_DTG1_SPEC_B,      8'h6E};
            8'd13: {addr_o, data_o} = {REG_DTG1_SPEC_C,      8'h28};
            8'd14: {addr_o, data_o} = {REG_DTG1_SPEC_D,      8'hDC};
            8'd15: {addr_o, data_o} = {REG_DTG1_TOT_PIX_MSB, TOT_PIX[15:8]};
            8'd16: {addr_o, data_o} = {REG_DTG1_TOT_PIX_LSB, TOT_PIX[7:0]};
            // frame and field size share one MSB register, two 3-bit fields
            8'd17: {addr_o, data_o} = {REG_DTG1_FRM_MSB,
                                       1'b0, TOT_LINES[10:8], 1'b0, TOT_LINES[10:8]};
            8'd18: {addr_o, data_o} = {REG_DTG1_FRM_LSB,     TOT_LINES[7:0]};
            8'd19: {addr_o, data_o} = {REG_DTG1_FLD_LSB,     TOT_LINES[7:0]};
            8'd20: {addr_o, data_o} = {REG_DTG1_ACT_MSB,     ACT_START[15:8]};
            8'd21: {addr_o, data_o} = {REG_DTG1_ACT_LSB,     ACT_START[7:0]};
            8'd22: {addr_o, data_o} = {REG_DTG2_CNTL,        8'h8C};
            // mode written last so the DTG starts with a complete raster setup
            8'd23: {addr_o, data_o} = {REG_DTG1_MODE,        DTG_MODE_720P};
            default: ;
        endcase
    end

endmodule

// File: rtl/ths8200_cfg_ctrl.sv
// Power-up I2C configuration sequencer for the THS8200 DAC; gates the 720p pipeline.
// Define THS8200_CFG_VERIFY_EN to read back and compare every register after writing it.
module ths8200_cfg_ctrl
    import ths8200_pkg::*;
#(
    parameter int         PWRUP_DLY_CYC = 7425000,
    parameter int         REG_NUM       = 24,
    parameter logic [7:0] DEV_ADDR      = 8'h40,
    parameter int         MAX_RETRY     = 3,
    parameter int         GAP_CYC       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_restart,
    output logic       i2c_req,
    output logic       i2c_rw,
    output logic [7:0] i2c_dev_addr,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_wr_data,
    input  logic       i2c_done,
    input  logic       i2c_ack_err,
    input  logic [7:0] i2c_rd_data,
    output logic [7:0] cfg_idx,
    output logic       cfg_err,
    output logic       da_init_done
);

    localparam int PW = (PWRUP_DLY_CYC > 1) ? $clog2(PWRUP_DLY_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef THS8200_CFG_VERIFY_EN
    localparam cfg_state_e WR_OK_ST = ST_RDREQ;
`else
    localparam cfg_state_e WR_OK_ST = ST_NEXT;
`endif

    cfg_state_e    state_q;
    logic [PW-1:0] pwr_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [RW-1:0] retry_q;
    logic          gap_to_load_q;
    logic          req_q;
    logic [7:0]    reg_addr_q, wr_data_q, idx_q;
    logic          err_q, init_done_q;
    logic [7:0]    rom_addr, rom_data;
    logic          xfer_ok;

    ths8200_reg_rom u_rom (
        .idx_i  (idx_q),
        .addr_o (rom_addr),
        .data_o (rom_data)
    );

`ifdef THS8200_CFG_VERIFY_EN
    logic rw_q;
    assign i2c_rw = rw_q;
    always_comb begin
        xfer_ok = !i2c_ack_err;
        if (state_q == ST_RDWAIT) xfer_ok = !i2c_ack_err && (i2c_rd_data == wr_data_q);
    end
`else
    logic unused_rd;
    assign unused_rd = ^i2c_rd_data;
    assign i2c_rw    = 1'b0;
    assign xfer_ok   = !i2c_ack_err;
`endif

    assign i2c_req      = req_q;
    assign i2c_dev_addr = DEV_ADDR | {7'b0, i2c_rw};
    assign i2c_reg_addr = reg_addr_q;
    assign i2c_wr_data  = wr_data_q;
    assign cfg_idx      = idx_q;
    assign cfg_err      = err_q;
    assign da_init_done = init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PWRUP;
            pwr_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            retry_q       <= '0;
            gap_to_load_q <= 1'b0;
            req_q         <= 1'b0;
            reg_addr_q    <= 8'h00;
            wr_data_q     <= 8'h00;
            idx_q         <= 8'h00;
            err_q         <= 1'b0;
            init_done_q   <= 1'b0;
`ifdef THS8200_CFG_VERIFY_EN
            rw_q          <= 1'b0;
`endif
        end else if (cfg_restart) begin
            init_done_q <= 1'b0;
            idx_q       <= 8'h00;
            err_q       <= 1'b0;
            retry_q     <= '0;
            req_q       <= 1'b0;
`ifdef THS8200_CFG_VERIFY_EN
            rw_q        <= 1'b0;
`endif
            // an outstanding transaction must finish on the bus before reuse
            state_q <= ((req_q || state_q == ST_DRAIN) && !i2c_done) ? ST_DRAIN : ST_LOAD;
        end else begin
            case (state_q)
                ST_PWRUP: begin
                    if (pwr_cnt_q == PW'(PWRUP_DLY_CYC - 1)) state_q <= ST_LOAD;
                    else pwr_cnt_q <= pwr_cnt_q + 1'b1;
                end
                ST_LOAD: begin
                    reg_addr_q <= rom_addr;
                    wr_data_q  <= rom_data;
                    retry_q    <= '0;
                    state_q    <= ST_REQ;
                end
                ST_REQ: begin
                    req_q   <= 1'b1;
                    state_q <= ST_WAIT;
                end
`ifdef THS8200_CFG_VERIFY_EN
                ST_RDREQ: begin
                    req_q   <= 1'b1;
                    rw_q    <= 1'b1;
                    state_q <= ST_RDWAIT;
                end
                ST_WAIT, ST_RDWAIT: begin
`else
                ST_WAIT: begin
`endif
                    if (i2c_done) begin
                        req_q <= 1'b0;
`ifdef THS8200_CFG_VERIFY_EN
                        rw_q  <= 1'b0;
`endif
                        if (xfer_ok) begin
                            state_q <= (state_q == ST_WAIT) ? WR_OK_ST : ST_NEXT;
                        end else if (retry_q == RW'(MAX_RETRY)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_FAIL;
                        end else begin
                            retry_q       <= retry_q + 1'b1;
                            gap_to_load_q <= 1'b0;
                            gap_cnt_q     <= '0;
                            state_q       <= ST_GAP;
                        end
                    end
                end
                ST_NEXT: begin
                    if (idx_q == 8'(REG_NUM - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q         <= idx_q + 1'b1;
                        gap_to_load_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYC - 1)) state_q <= gap_to_load_q ? ST_LOAD : ST_REQ;
                    else gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                ST_DONE:  init_done_q <= 1'b1;
                ST_FAIL:  ;
                ST_DRAIN: if (i2c_done) state_q <= ST_LOAD;
                default:  state_q <= ST_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_ths8200_cfg_ctrl.sv
// Directed bench for ths8200_cfg_ctrl with a fixed-latency I2C master model.
module tb_ths8200_cfg_ctrl;

    localparam int PWR  = 100;
    localparam int NREG = 24;
    localparam int GAP  = 16;
    localparam int DLAT = 20;

    logic       clk = 1'b0, rst_n = 1'b0, cfg_restart = 1'b0;
    logic       i2c_req, i2c_rw, cfg_err, da_init_done;
    logic [7:0] i2c_dev_addr, i2c_reg_addr, i2c_wr_data, cfg_idx;
    logic       i2c_done = 1'b0, i2c_ack_err = 1'b0;
    logic [7:0] i2c_rd_data = 8'h00;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int nack_idx = 5, nack_n = 0;
    int lg_idx[$], lg_addr[$], lg_data[$], lg_dev[$], lg_cyc[$], lg_low[$];

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[NREG];

    ths8200_cfg_ctrl #(
        .PWRUP_DLY_CYC (PWR),
        .REG_NUM       (NREG),
        .DEV_ADDR      (8'h40),
        .MAX_RETRY     (3),
        .GAP_CYC       (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_restart  (cfg_restart),
        .i2c_req      (i2c_req),
        .i2c_rw       (i2c_rw),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_wr_data  (i2c_wr_data),
        .i2c_done     (i2c_done),
        .i2c_ack_err  (i2c_ack_err),
        .i2c_rd_data  (i2c_rd_data),
        .cfg_idx      (cfg_idx),
        .cfg_err      (cfg_err),
        .da_init_done (da_init_done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // I2C master model: done DLAT cycles after each req rise; NACKs entry nack_idx nack_n times
    initial begin
        int busy, cnt, low, given;
        logic prev;
        busy = 0; cnt = 0; low = 0; given = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack_err = 1'b0;
            if (!rst_n) begin
                busy = 0; low = 0; given = 0; prev = 1'b0;
            end else begin
                if (i2c_req && !prev) begin
                    lg_idx.push_back(int'(cfg_idx));
                    lg_addr.push_back(int'(i2c_reg_addr));
                    lg_data.push_back(int'(i2c_wr_data));
                    lg_dev.push_back(int'(i2c_dev_addr));
                    lg_cyc.push_back(cyc);
                    lg_low.push_back(low);
                    if (int'(cfg_idx) != nack_idx) given = 0;
                    busy = 1; cnt = DLAT; low = 0;
                end else if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 0;
                        i2c_done = 1'b1;
                        i2c_rd_data = i2c_wr_data;
                        if (int'(cfg_idx) == nack_idx && given < nack_n) begin
                            i2c_ack_err = 1'b1;
                            given++;
                        end
                    end
                end
                if (!i2c_req) low++;
                prev = i2c_req;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk); cfg_restart = 1'b1;
        @(negedge clk); cfg_restart = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        for (int k = 0; k < 3000 && !da_init_done; k++) @(negedge clk);
        chk({tag, "_init_done"}, int'(da_init_done), 1);
    endtask

    task automatic check_seq(input int base, input string tag);
        chk({tag, "_nwrites"}, lg_addr.size() - base, NREG);
        for (int i = 0; i < NREG && base + i < lg_addr.size(); i++) begin
            chk($sformatf("%s_idx%0d", tag, i),  lg_idx[base+i],  tbl[i].idx);
            chk($sformatf("%s_addr%0d", tag, i), lg_addr[base+i], int'(tbl[i].addr));
            chk($sformatf("%s_data%0d", tag, i), lg_data[base+i], int'(tbl[i].data));
            chk($sformatf("%s_dev%0d", tag, i),  lg_dev[base+i],  32'h40);
        end
    endtask

    function automatic int count_idx(input int base, input int idx);
        int n = 0;
        for (int i = base; i < lg_idx.size(); i++) if (lg_idx[i] == idx) n++;
        return n;
    endfunction

    initial begin
        int base, rel, rc, n, seen;
        tbl[0]  = '{0,  8'h03, 8'h01}; tbl[1]  = '{1,  8'h19, 8'h03}; tbl[2]  = '{2,  8'h1C, 8'h03};
        tbl[3]  = '{3,  8'h1D, 8'h15}; tbl[4]  = '{4,  8'h1E, 8'h00}; tbl[5]  = '{5,  8'h1F, 8'h00};
        tbl[6]  = '{6,  8'h20, 8'hFF}; tbl[7]  = '{7,  8'h21, 8'h15}; tbl[8]  = '{8,  8'h22, 8'h00};
        tbl[9]  = '{9,  8'h23, 8'h00}; tbl[10] = '{10, 8'h24, 8'hFF}; tbl[11] = '{11, 8'h28, 8'h28};
        tbl[12] = '{12, 8'h29, 8'h6E}; tbl[13] = '{13, 8'h2A, 8'h28}; tbl[14] = '{14, 8'h2B, 8'hDC};
        tbl[15] = '{15, 8'h34, 8'h06}; tbl[16] = '{16, 8'h35, 8'h72}; tbl[17] = '{17, 8'h39, 8'h22};
        tbl[18] = '{18, 8'h3A, 8'hEE}; tbl[19] = '{19, 8'h3B, 8'hEE}; tbl[20] = '{20, 8'h3C, 8'h01};
        tbl[21] = '{21, 8'h3D, 8'h73}; tbl[22] = '{22, 8'h4A, 8'h8C}; tbl[23] = '{23, 8'h38, 8'h81};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req", int'(i2c_req), 0);
        chk("rst_rw", int'(i2c_rw), 0);
        chk("rst_reg_addr", int'(i2c_reg_addr), 0);
        chk("rst_wr_data", int'(i2c_wr_data), 0);
        chk("rst_idx", int'(cfg_idx), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_init_done", int'(da_init_done), 0);

        // clean power-up sequence
        base = lg_addr.size(); rel = cyc; rst_n = 1'b1;
        wait_init("t1");
        chk("t1_pwrup_lat_ok", (lg_addr.size() > base && lg_cyc[base] - rel >= 101
                                && lg_cyc[base] - rel <= 103) ? 1 : 0, 1);
        check_seq(base, "t1");
        chk("t1_err", int'(cfg_err), 0);
        chk("t1_last_idx", int'(cfg_idx), NREG - 1);

        // restart from DONE with entry 5 NACKed twice
        nack_n = 2; base = lg_addr.size();
        pulse_restart(); rc = cyc;
        chk("t2_init_done_fall", int'(da_init_done), 0);
        wait_init("t2");
        chk("t2_no_pwrup", (lg_addr.size() > base && lg_cyc[base] - rc < 10) ? 1 : 0, 1);
        chk("t2_nwrites", lg_addr.size() - base, NREG + 2);
        chk("t2_entry5_attempts", count_idx(base, 5), 3);
        seen = 0;
        for (int i = base; i < lg_idx.size(); i++)
            if (lg_idx[i] == 5) begin
                if (seen > 0)
                    chk($sformatf("t2_retry_gap%0d_ok", seen),
                        (lg_low[i] >= GAP && lg_low[i] <= GAP + 2) ? 1 : 0, 1);
                seen++;
            end
        chk("t2_err", int'(cfg_err), 0);

        // entry 5 NACKed beyond the retry budget
        nack_n = 4; base = lg_addr.size();
        pulse_restart();
        for (int k = 0; k < 3000 && !cfg_err; k++) @(negedge clk);
        chk("t3_err", int'(cfg_err), 1);
        chk("t3_idx", int'(cfg_idx), 5);
        chk("t3_entry5_attempts", count_idx(base, 5), 4);
        n = lg_addr.size();
        repeat (200) @(negedge clk);
        chk("t3_no_more_req", lg_addr.size() - n, 0);
        chk("t3_req_low", int'(i2c_req), 0);
        chk("t3_init_done", int'(da_init_done), 0);

        // leave FAIL, then abort mid-WAIT on entry 10
        nack_n = 0;
        pulse_restart();
        chk("t4_err_cleared", int'(cfg_err), 0);
        for (int k = 0; k < 3000 && !(i2c_req === 1'b1 && cfg_idx == 8'd10); k++) @(negedge clk);
        chk("t4_reached_entry10", (i2c_req === 1'b1 && cfg_idx == 8'd10) ? 1 : 0, 1);
        repeat (5) @(negedge clk);
        base = lg_addr.size();
        pulse_restart(); rc = cyc;
        chk("t4_req_drop", int'(i2c_req), 0);
        chk("t4_idx_clear", int'(cfg_idx), 0);
        wait_init("t4");
        chk("t4_waits_stale_done", (lg_addr.size() > base && lg_cyc[base] - rc >= 10
                                    && lg_cyc[base] - rc < 40) ? 1 : 0, 1);
        check_seq(base, "t4");
        chk("t4_err", int'(cfg_err), 0);

        // asynchronous reset mid-sequence
        pulse_restart();
        repeat (300) @(negedge clk);
        chk("t6_midseq_idx_nonzero", (cfg_idx != 8'd0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_req", int'(i2c_req), 0);
        chk("t6_async_idx", int'(cfg_idx), 0);
        chk("t6_async_reg_addr", int'(i2c_reg_addr), 0);
        chk("t6_async_wr_data", int'(i2c_wr_data), 0);
        chk("t6_async_init_done", int'(da_init_done), 0);
        repeat (3) @(negedge clk);
        base = lg_addr.size(); rel = cyc; rst_n = 1'b1;
        for (int k = 0; k < 300 && lg_addr.size() == base; k++) @(negedge clk);
        chk("t6_pwrup_lat_ok", (lg_addr.size() > base && lg_cyc[base] - rel >= 101
                                && lg_cyc[base] - rel <= 103) ? 1 : 0, 1);
        if (lg_addr.size() > base) begin
            chk("t6_first_addr", lg_addr[base], 32'h03);
            chk("t6_first_data", lg_data[base], 32'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ths8200_cfg_ctrl.md
Name: ths8200_cfg_ctrl

Overview:
Power-up configuration sequencer for the THS8200 video DAC.
- After a power-up delay, walks a fixed table of register address/data pairs and issues one I2C write per entry through a byte-level I2C master handshake.
- Retries entries that are NACKed.
- Asserts da_init_done, which gates the 720p timing generator and pixel driver.
- Sits between the board I2C master and the video output driver, in the 74.25 MHz pixel clock domain.

Parameters:
- PWRUP_DLY_CYC, 7425000: cycles to wait after reset before the first write (100 ms at 74.25 MHz).
- REG_NUM, 24: number of table entries (1..256).
- DEV_ADDR, 8'h40: 8-bit write address of the THS8200.
- MAX_RETRY, 3: retries per entry after the first attempt.
- GAP_CYC, 16: idle cycles between consecutive transactions.

Ports:
- clk, input, 1: pixel clock. Single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- cfg_restart, input, 1: one-cycle pulse; aborts and reruns the whole sequence, skipping the power-up delay.
- i2c_req, output, 1: transaction request; held high until i2c_done.
- i2c_rw, output, 1: 0 = write, 1 = read.
- i2c_dev_addr, output, 8: device address; always DEV_ADDR (read uses DEV_ADDR|1).
- i2c_reg_addr, output, 8: register address.
- i2c_wr_data, output, 8: write data.
- i2c_done, input, 1: one-cycle completion pulse from the I2C master.
- i2c_ack_err, input, 1: NACK flag; valid only when i2c_done is high.
- i2c_rd_data, input, 8: read data; valid when i2c_done is high.
- cfg_idx, output, 8: index of the current entry.
- cfg_err, output, 1: sticky; entry failed after all retries.
- da_init_done, output, 1: configuration complete; level signal.

Behaviour:
Reset values: i2c_req=0, i2c_rw=0, i2c_reg_addr=0, i2c_wr_data=0, cfg_idx=0, cfg_err=0, da_init_done=0. The FSM enters PWRUP.

FSM states:
- PWRUP: counter runs from 0 to PWRUP_DLY_CYC-1, then go to LOAD.
- LOAD: latch table[cfg_idx] into i2c_reg_addr/i2c_wr_data, clear the retry count, go to REQ.
- REQ: drive i2c_req=1 (registered, so it rises the cycle after entering REQ), go to WAIT.
- WAIT: hold i2c_req and the address/data stable until i2c_done.
  - On i2c_done, drop i2c_req in the same edge.
  - ack_err=0: go to NEXT.
  - ack_err=1 and retry < MAX_RETRY: increment retry, go to GAP, then REQ.
  - ack_err=1 and retry = MAX_RETRY: set cfg_err, go to FAIL.
- NEXT: if cfg_idx = REG_NUM-1, go to DONE. Otherwise increment cfg_idx, go to GAP, then LOAD.
- GAP: wait GAP_CYC cycles with i2c_req=0.
- DONE: da_init_done=1 from the cycle after entry. Held until reset or cfg_restart.
- FAIL: da_init_done stays 0, cfg_err stays 1. Only cfg_restart or reset leaves this state.

cfg_restart rules:
- In any state, clear da_init_done, cfg_idx, cfg_err and the retry count, then go to LOAD.
- If i2c_req is high, drop it. Any later i2c_done for the aborted transaction is ignored. The FSM stays in a DRAIN sub-state until that done arrives, then goes to LOAD.
- cfg_restart has priority over i2c_done in the same cycle.

Handshake and counters:
- i2c_done received while not in WAIT/DRAIN is ignored.
- The power-up counter is a $clog2(PWRUP_DLY_CYC)-bit counter and does not wrap.
- cfg_idx never exceeds REG_NUM-1.
- Table contents cover the 720p 4:2:2 embedded-sync setup:
  - 0x03 = 0x01 (chip control)
  - dtg mode 720p
  - total pixels 1650, total lines 750, active start 371
  - CSC bypass

Optional Feature:
THS8200_CFG_VERIFY_EN:
- Defined: after each successful write, issue a read (i2c_rw=1, same reg addr) via states RDREQ/RDWAIT.
  - Compare i2c_rd_data with the table data.
  - A mismatch or NACK counts as a failed attempt for the retry logic; the retry restarts with the write.
- Undefined: i2c_rw is tied 0, i2c_rd_data is unused, and those states are absent.

Decomposition:
- Shared package ths8200_pkg:
  - FSM state enum
  - THS8200 register address constants
  - 720p timing constants 1650/750/371
- Sub-module ths8200_reg_rom: combinational index-to {addr[7:0], data[7:0]} lookup, REG_NUM entries.

Test Plan:
1. Reset, PWRUP_DLY_CYC=100, ideal I2C model (done 20 cycles after req, no NACK) -> first i2c_req at cycle 102 ±1 with reg 0x03/data 0x01; exactly REG_NUM writes in table order; da_init_done=1 after the last done; cfg_err=0.
2. NACK entry 5 twice, then ACK -> entry 5 issued 3 times, GAP_CYC low cycles between attempts; sequence completes; cfg_err=0.
3. NACK entry 5 four times with MAX_RETRY=3 -> cfg_err=1, cfg_idx=5, da_init_done stays 0, no further i2c_req.
4. cfg_restart mid-WAIT on entry 10 -> i2c_req drops next cycle; the stale done is ignored; restart from entry 0 with no power-up delay; completes normally.
5. cfg_restart from DONE -> da_init_done falls the next cycle; full sequence reruns.
6. Assert rst_n low mid-sequence -> all outputs reset asynchronously; PWRUP delay reapplied after release.
